// File: rtl/pac_arm_pkg.sv
// -----------------------------------------------------------------------------
// pac_arm_pkg
// Shared definitions for the ARM-style pipeline front end:
//   - fetch_state_t : fetch-stage FSM states
//   - *_MSB/*_LSB   : instruction field bit positions
//   - NOP_INSTR     : MOV r0,r0 (cond AL), also used by later flush logic
//   - word_align()  : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package pac_arm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HAVE = 2'd2,
        S_ERR  = 2'd3
    } fetch_state_t;

    localparam int COND_MSB  = 31;
    localparam int COND_LSB  = 28;
    localparam int OP_MSB    = 27;
    localparam int OP_LSB    = 26;
    localparam int OPC_MSB   = 25;
    localparam int OPC_LSB   = 20;
    localparam int RN_MSB    = 19;
    localparam int RN_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 12;
    localparam int RM_MSB    = 3;
    localparam int RM_LSB    = 0;
    localparam int IMM12_MSB = 11;
    localparam int IMM24_MSB = 23;

    localparam logic [31:0] NOP_INSTR    = 32'hE1A0_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] PC_VIS_OFFS  = 32'd8;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// -----------------------------------------------------------------------------
// fetch_wait_counter
// Counts cycles spent waiting for an instruction-memory acknowledge.
// Saturates at its terminal value; term_o flags that the next unacknowledged
// cycle is the last one allowed. TIMEOUT=0 disables the terminal flag.
// Ports:
//   clk     in  clock, rising edge
//   rst     in  synchronous active-high reset
//   clr_i   in  clear count to zero (takes priority over en_i)
//   en_i    in  count one waiting cycle
//   term_o  out count has reached TIMEOUT-1 (never set when TIMEOUT=0)
// -----------------------------------------------------------------------------
module fetch_wait_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sat;

    assign term_o = (TIMEOUT != 0) && (cnt_q == TERM_VAL);
    // All-ones bound keeps the count from wrapping when the terminal flag is disabled.
    assign sat    = term_o || (cnt_q == {CNT_W{1'b1}});

    // NOTE: default assignment first so every path writes cnt_d and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !sat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
// Holds the PC, fetches one instruction word at a time over a req/ack port,
// and presents the word plus its decoded fields to control unit and datapath.
// Ports:
//   clk, rst            clock / synchronous active-high reset
//   imem_req/addr       fetch request (held until ack) and its word address
//   imem_ack/rdata      memory response, accepted only while requesting
//   instr_valid         instruction register holds an unretired word
//   instr_ready         datapath retires the current instruction
//   selPC/branch_target branch decision and target, sampled on retire only
//   instr               instruction register, or NOP_INSTR when not valid
//   condicion..imm24    field slices of instr
//   pc_out/pc_plus8     address of current instruction and that address + 8
//   fetch_err           sticky timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module instr_fetch_stage
    import pac_arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = pac_arm_pkg::NOP_INSTR,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        selPC,
    input  logic [31:0] branch_target,
    output logic [31:0] instr,
    output logic [3:0]  condicion,
    output logic [1:0]  operation,
    output logic [5:0]  opcodes,
    output logic [3:0]  rn,
    output logic [3:0]  rd,
    output logic [3:0]  rm,
    output logic [11:0] imm12,
    output logic [23:0] imm24,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus8,
    output logic        fetch_err
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  ir_q;
    logic         req_q;
    logic         valid_q;
    logic         err_q;
    logic         retire;
    logic         wait_term;

    assign retire = (state_q == S_HAVE) && instr_ready;

    // Branch target and selPC are only looked at on the retire cycle.
    always_comb begin
        pc_d = pc_q;
        if (retire) begin
            pc_d = selPC ? word_align(branch_target) : pc_q + PC_STEP;
        end
    end

    fetch_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (retire),
        .en_i   ((state_q == S_REQ) && !imem_ack),
        .term_o (wait_term)
    );

    // FSM with registered request/valid/error outputs. An ack outside S_REQ
    // (including a late ack for a request abandoned by rst) falls through untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= word_align(RESET_PC);
            ir_q    <= NOP_INSTR;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q <= pc_d;
            unique case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        state_q <= S_HAVE;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end else if (wait_term) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                        req_q   <= 1'b0;
                    end
                end
                S_HAVE: begin
                    if (instr_ready) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                S_ERR: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;
    assign instr       = valid_q ? ir_q : NOP_INSTR;
    assign pc_out      = pc_q;
    assign pc_plus8    = pc_q + PC_VIS_OFFS;

    // Fields come from instr, so they read as NOP fields whenever instr_valid=0.
    assign condicion = instr[COND_MSB:COND_LSB];
    assign operation = instr[OP_MSB:OP_LSB];
    assign opcodes   = instr[OPC_MSB:OPC_LSB];
    assign rn        = instr[RN_MSB:RN_LSB];
    assign rd        = instr[RD_MSB:RD_LSB];
    assign rm        = instr[RM_MSB:RM_LSB];
    assign imm12     = instr[IMM12_MSB:0];
    assign imm24     = instr[IMM24_MSB:0];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
// Directed scenarios plus a randomized run against a cycle-level behavioural
// model of the fetch protocol. A second instance with RESET_PC=FFFF_FFFC
// shares the stimulus and is checked for PC wrap-around.
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP     = 32'hE1A0_0000;
    localparam int          TMO     = 16;

    logic        clk = 1'b0;
    logic        rst, imem_ack, instr_ready, selPC;
    logic [31:0] imem_rdata, branch_target;

    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, instr, pc_out, pc_plus8;
    logic [3:0]  condicion, rn, rd, rm;
    logic [1:0]  operation;
    logic [5:0]  opcodes;
    logic [11:0] imm12;
    logic [23:0] imm24;

    logic        w_req, w_valid, w_err;
    logic [31:0] w_addr, w_instr, w_pc, w_pc8;
    logic [3:0]  w_cond, w_rn, w_rd, w_rm;
    logic [1:0]  w_op;
    logic [5:0]  w_opc;
    logic [11:0] w_imm12;
    logic [23:0] w_imm24;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .selPC(selPC), .branch_target(branch_target),
        .instr(instr), .condicion(condicion), .operation(operation), .opcodes(opcodes),
        .rn(rn), .rd(rd), .rm(rm), .imm12(imm12), .imm24(imm24),
        .pc_out(pc_out), .pc_plus8(pc_plus8), .fetch_err(fetch_err)
    );

    instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP), .TIMEOUT(TMO)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(w_valid),
        .instr_ready(instr_ready), .selPC(selPC), .branch_target(branch_target),
        .instr(w_instr), .condicion(w_cond), .operation(w_op), .opcodes(w_opc),
        .rn(w_rn), .rd(w_rd), .rm(w_rm), .imm12(w_imm12), .imm24(w_imm24),
        .pc_out(w_pc), .pc_plus8(w_pc8), .fetch_err(w_err)
    );

    // Advance one cycle and settle away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        instr_ready = 1'b0; selPC = 1'b0; branch_target = '0;
        tick(); tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        n_cmp++; if (instr !== NOP) begin n_bad++; $display("FAIL rst_instr: got %h want %h", instr, NOP); end
        n_cmp++; if (fetch_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", fetch_err); end
        n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", pc_out); end
        n_cmp++; if (condicion !== 4'hE) begin n_bad++; $display("FAIL rst_cond: got %h want e", condicion); end
        n_cmp++; if (w_req !== 1'b0) begin n_bad++; $display("FAIL rst_wreq: got %b want 0", w_req); end
        rst = 1'b0; imem_ack = 1'b0;
        tick();  // one bubble, then first request
    endtask

    task automatic test_same_cycle_ack();
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL t1_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL t1_addr0: got %h want 0", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'hE081_0002;
        tick();
        imem_ack = 1'b0;
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL t1_valid: got %b want 1", instr_valid); end
        n_cmp++; if (instr !== 32'hE081_0002) begin n_bad++; $display("FAIL t1_instr: got %h want e0810002", instr); end
        n_cmp++; if (condicion !== 4'hE) begin n_bad++; $display("FAIL t1_cond: got %h want e", condicion); end
        n_cmp++; if (operation !== 2'b00) begin n_bad++; $display("FAIL t1_op: got %b want 00", operation); end
        n_cmp++; if (opcodes !== 6'b001000) begin n_bad++; $display("FAIL t1_opc: got %b want 001000", opcodes); end
        n_cmp++; if (rn !== 4'd1) begin n_bad++; $display("FAIL t1_rn: got %0d want 1", rn); end
        n_cmp++; if (rd !== 4'd0) begin n_bad++; $display("FAIL t1_rd: got %0d want 0", rd); end
        n_cmp++; if (rm !== 4'd2) begin n_bad++; $display("FAIL t1_rm: got %0d want 2", rm); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL t1_req_drop: got %b want 0", imem_req); end
        instr_ready = 1'b1; selPC = 1'b0;
        tick();
        instr_ready = 1'b0;
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL t1_req2: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL t1_addr4: got %h want 4", imem_addr); end
        n_cmp++; if (instr !== NOP) begin n_bad++; $display("FAIL t1_nop: got %h want %h", instr, NOP); end
    endtask

    task automatic test_delayed_ack();
        logic [31:0] word;
        word = $urandom;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL t2_req[%0d]: got %b want 1", k, imem_req); end
            n_cmp++; if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL t2_addr[%0d]: got %h want 4", k, imem_addr); end
            if (k < 3) tick();
        end
        imem_ack = 1'b1; imem_rdata = word;
        tick();
        imem_ack = 1'b0; imem_rdata = ~word;
        n_cmp++; if (instr !== word) begin n_bad++; $display("FAIL t2_instr: got %h want %h", instr, word); end
        n_cmp++; if (fetch_err !== 1'b0) begin n_bad++; $display("FAIL t2_err: got %b want 0", fetch_err); end
        tick();
        n_cmp++; if (instr !== word) begin n_bad++; $display("FAIL t2_one_load: got %h want %h", instr, word); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL t2_noreq: got %b want 0", imem_req); end
    endtask

    task automatic test_branch();
        instr_ready = 1'b1; selPC = 1'b1; branch_target = 32'h100;
        tick();
        instr_ready = 1'b0; selPC = 1'b0;
        n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL t3_addr100: got %h want 100", imem_addr); end
        imem_ack = 1'b1; imem_rdata = $urandom;
        tick();
        imem_ack = 1'b0;
        instr_ready = 1'b1; selPC = 1'b1; branch_target = 32'h203;
        tick();
        instr_ready = 1'b0; selPC = 1'b0; branch_target = '0;
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL t3_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h200) begin n_bad++; $display("FAIL t3_addr200: got %h want 200", imem_addr); end
        imem_ack = 1'b1; imem_rdata = $urandom;
        tick();
        imem_ack = 1'b0;
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL t3_valid: got %b want 1", instr_valid); end
        n_cmp++; if (pc_plus8 !== 32'h208) begin n_bad++; $display("FAIL t3_pc8: got %h want 208", pc_plus8); end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        held = instr;
        for (int k = 0; k < 5; k++) begin
            instr_ready = 1'b0; selPC = k[0]; branch_target = $urandom;
            imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
            tick();
            n_cmp++; if (instr !== held) begin n_bad++; $display("FAIL t4_instr[%0d]: got %h want %h", k, instr, held); end
            n_cmp++; if (pc_out !== 32'h200) begin n_bad++; $display("FAIL t4_pc[%0d]: got %h want 200", k, pc_out); end
            n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL t4_req[%0d]: got %b want 0", k, imem_req); end
        end
        imem_ack = 1'b0; instr_ready = 1'b1; selPC = 1'b0;
        tick();
        instr_ready = 1'b0;
        n_cmp++; if (imem_addr !== 32'h204) begin n_bad++; $display("FAIL t4_next: got %h want 204", imem_addr); end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < TMO; k++) begin
            n_cmp++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
                n_bad++; $display("FAIL t5_wait[%0d]: got req=%b err=%b want req=1 err=0", k, imem_req, fetch_err);
            end
            tick();
        end
        n_cmp++; if (fetch_err !== 1'b1) begin n_bad++; $display("FAIL t5_err: got %b want 1", fetch_err); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL t5_req: got %b want 0", imem_req); end
        imem_ack = 1'b1;
        tick(); tick();
        imem_ack = 1'b0;
        n_cmp++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL t5_stuck: got err=%b req=%b valid=%b want 1 0 0", fetch_err, imem_req, instr_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (fetch_err !== 1'b0) begin n_bad++; $display("FAIL t5_clr: got %b want 0", fetch_err); end
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_bad++; $display("FAIL t5_refetch: got req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
            n_bad++; $display("FAIL t6_first: got req=%b addr=%h want 1 fffffffc", w_req, w_addr);
        end
        imem_ack = 1'b1; imem_rdata = $urandom;
        tick();
        imem_ack = 1'b0;
        n_cmp++; if (w_pc8 !== 32'h4) begin n_bad++; $display("FAIL t6_pc8: got %h want 4", w_pc8); end
        instr_ready = 1'b1; selPC = 1'b0;
        tick();
        instr_ready = 1'b0;
        n_cmp++; if (w_addr !== 32'h0 || w_req !== 1'b1) begin
            n_bad++; $display("FAIL t6_wrap: got req=%b addr=%h want 1 0", w_req, w_addr);
        end
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        n_cmp++; if (w_instr !== NOP || w_req !== 1'b0) begin
            n_bad++; $display("FAIL t6_rst_ack: got instr=%h req=%b want %h 0", w_instr, w_req, NOP);
        end
        tick();  // late ack lands in the post-reset bubble
        imem_ack = 1'b0;
        n_cmp++; if (w_valid !== 1'b0 || w_instr !== NOP) begin
            n_bad++; $display("FAIL t6_late_ack: got valid=%b instr=%h want 0 %h", w_valid, w_instr, NOP);
        end
        n_cmp++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
            n_bad++; $display("FAIL t6_refetch: got req=%b addr=%h want 1 fffffffc", w_req, w_addr);
        end
    endtask

    // Behavioural model: a fetch is outstanding, a word is held, or the stage
    // has timed out; a reset is always followed by one idle cycle.
    task automatic test_random();
        logic [31:0] m_pc, m_ir, e_instr;
        bit          m_bubble, m_req, m_valid, m_err;
        int          m_wait;
        rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; selPC = 1'b0;
        tick();
        m_pc = 32'h0; m_ir = NOP; m_bubble = 1; m_req = 0; m_valid = 0; m_err = 0; m_wait = 0;
        for (int c = 0; c < 600; c++) begin
            rst           = ($urandom_range(0, 99) < 2);
            imem_ack      = ($urandom_range(0, 9) < 5);
            instr_ready   = 1'($urandom_range(0, 1));
            selPC         = 1'($urandom_range(0, 1));
            branch_target = $urandom;
            imem_rdata    = $urandom;
            if (rst) begin
                m_pc = 32'h0; m_ir = NOP; m_bubble = 1; m_req = 0; m_valid = 0; m_err = 0; m_wait = 0;
            end else if (m_bubble) begin
                m_bubble = 0; m_req = 1;
            end else if (m_req) begin
                if (imem_ack) begin
                    m_ir = imem_rdata; m_req = 0; m_valid = 1;
                end else if (m_wait == TMO - 1) begin
                    m_err = 1; m_req = 0;
                end else begin
                    m_wait++;
                end
            end else if (m_valid && instr_ready) begin
                m_pc    = selPC ? (branch_target & ~32'd3) : m_pc + 32'd4;
                m_wait  = 0;
                m_valid = 0;
                m_req   = 1;
            end
            tick();
            e_instr = m_valid ? m_ir : NOP;
            n_cmp++; if (imem_req !== m_req) begin n_bad++; $display("FAIL rnd_req@%0d: got %b want %b", c, imem_req, m_req); end
            if (m_req) begin
                n_cmp++; if (imem_addr !== m_pc) begin n_bad++; $display("FAIL rnd_addr@%0d: got %h want %h", c, imem_addr, m_pc); end
            end
            n_cmp++; if (instr_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid@%0d: got %b want %b", c, instr_valid, m_valid); end
            n_cmp++; if (instr !== e_instr) begin n_bad++; $display("FAIL rnd_instr@%0d: got %h want %h", c, instr, e_instr); end
            n_cmp++; if (pc_out !== m_pc) begin n_bad++; $display("FAIL rnd_pc@%0d: got %h want %h", c, pc_out, m_pc); end
            n_cmp++; if (pc_plus8 !== m_pc + 32'd8) begin n_bad++; $display("FAIL rnd_pc8@%0d: got %h want %h", c, pc_plus8, m_pc + 32'd8); end
            n_cmp++; if (fetch_err !== m_err) begin n_bad++; $display("FAIL rnd_err@%0d: got %b want %b", c, fetch_err, m_err); end
            n_cmp++; if ({opcodes, rn, imm24} !== {e_instr[25:20], e_instr[19:16], e_instr[23:0]}) begin
                n_bad++; $display("FAIL rnd_fields@%0d: got %b/%h/%h want from %h", c, opcodes, rn, imm24, e_instr);
            end
        end
        rst = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_same_cycle_ack();
        test_delayed_ack();
        test_branch();
        test_stall();
        test_timeout();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
